// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline front end.
// Pipeline stages import this package to get widths, the NOP encoding and the PC stride.
package mips_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_STEP      = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Word-aligns an address by clearing its two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection (redirect / hold / step).
// Also flags redirect targets that are not word-aligned.
module pc_reg
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;

    assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

    // Redirect wins over stall; the adder wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
        end else if (!stall) begin
            pc_d = pc_plus4;
        end
    end

    assign misalign_d = redirect_valid & (|redirect_target[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction-memory address and the IF/ID register.
// Redirect and flush squash IF/ID; stall freezes both the PC and IF/ID.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = INSTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              flush,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_reg (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .misalign_err    (misalign_err)
    );

    assign imem_addr = pc;

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;
    logic              squash;
    logic              load;

    // Squash beats stall, so a redirect during a load-use stall still drops the wrong-path word.
    assign squash = redirect_valid | flush;
    assign load   = !squash && !stall;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (squash) begin
            instr_d = DATA_W'(NOP_INSTR);
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= DATA_W'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule
